// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier writeback path.
package mul_pkg;
  localparam int MUL_LAT = 3;
  localparam int ROB_W   = 5;
  localparam int GPR_W   = 6;
  localparam int HILO_W  = 2;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MUL   = 3'd4
  } mul_op_e;

  typedef struct packed {
    logic [63:0]       y;
    logic [ROB_W-1:0]  rob_ptr;
    logic              gpr_val;
    logic [GPR_W-1:0]  gpr_ptr;
    logic              hilo_val;
    logic [HILO_W-1:0] hilo_ptr;
  } mul_wb_entry_t;
endpackage

// File: rtl/mul_wb_queue_if.sv
// Issue/complete inputs and writeback handshake of the multiply queue.
interface mul_wb_queue_if;
  import mul_pkg::*;

  logic              flush;
  logic              mul_go;
  logic              mul_can_issue;
  logic              mul_complete;
  logic [63:0]       mul_y;
  logic [ROB_W-1:0]  mul_rob_ptr;
  logic              mul_gpr_val;
  logic [GPR_W-1:0]  mul_gpr_ptr;
  logic              mul_hilo_val;
  logic [HILO_W-1:0] mul_hilo_ptr;
  logic              wb_valid;
  logic              wb_ready;
  logic [ROB_W-1:0]  wb_rob_ptr;
  logic              wb_gpr_val;
  logic [GPR_W-1:0]  wb_gpr_ptr;
  logic [31:0]       wb_gpr_data;
  logic              wb_hilo_val;
  logic [HILO_W-1:0] wb_hilo_ptr;
  logic [63:0]       wb_hilo_data;
  logic              overflow_err;

  modport master (
    output flush, mul_go, mul_complete, mul_y,
    output mul_rob_ptr, mul_gpr_val, mul_gpr_ptr,
    output mul_hilo_val, mul_hilo_ptr, wb_ready,
    input  mul_can_issue, wb_valid, wb_rob_ptr,
    input  wb_gpr_val, wb_gpr_ptr, wb_gpr_data,
    input  wb_hilo_val, wb_hilo_ptr, wb_hilo_data,
    input  overflow_err
  );

  modport slave (
    input  flush, mul_go, mul_complete, mul_y,
    input  mul_rob_ptr, mul_gpr_val, mul_gpr_ptr,
    input  mul_hilo_val, mul_hilo_ptr, wb_ready,
    output mul_can_issue, wb_valid, wb_rob_ptr,
    output wb_gpr_val, wb_gpr_ptr, wb_gpr_data,
    output wb_hilo_val, wb_hilo_ptr, wb_hilo_data,
    output overflow_err
  );
endinterface

// File: rtl/mul_wb_fifo.sv
// DEPTH-entry FIFO of writeback entries; a push into a full FIFO
// only lands when the head leaves in the same cycle.
module mul_wb_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  mul_wb_entry_t            i_wdata,
  output mul_wb_entry_t            o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  mul_wb_entry_t r_mem [DEPTH];

  logic w_wr;
  logic w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop & ~o_empty & ~i_flush;
  assign w_wr    = i_push & ~i_flush & (~o_full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + 1'b1;
      if (w_rd) r_head <= r_head + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
endmodule

// File: rtl/mul_wb_queue.sv
// Buffers fixed-latency multiply completions for the writeback port
// and hands out issue credit so the buffer can never overflow.
module mul_wb_queue
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  mul_wb_queue_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = CW + 1;

  logic [MUL_LAT-1:0] r_s;
  logic [MUL_LAT-1:0] r_v;
  logic               r_ovf;

  logic [CW-1:0] w_count;
  logic [PW-1:0] w_pending;
  logic          w_full;
  logic          w_empty;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  mul_wb_entry_t w_wdata;
  mul_wb_entry_t w_head;
  mul_wb_entry_t w_out;

  // s counts every issued op, v only the ones that survive a flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s   <= '0;
      r_v   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_s <= {r_s[MUL_LAT-2:0], bus.mul_go};
      r_v <= {r_v[MUL_LAT-2:0], bus.mul_go}
             & {MUL_LAT{~bus.flush}};
      if (w_ovf_evt) r_ovf <= 1'b1;
    end
  end

  assign w_pending = PW'(w_count) + PW'($countones(r_s));
  assign bus.mul_can_issue = (w_pending < PW'(DEPTH));

  assign w_valid = ~w_empty;
  assign w_push  = bus.mul_complete & r_v[MUL_LAT-1] & ~bus.flush;
  assign w_pop   = w_valid & bus.wb_ready & ~bus.flush;

  assign w_ovf_evt = (bus.mul_complete & ~r_s[MUL_LAT-1])
                   | (w_push & w_full & ~w_pop);

  assign w_wdata = '{
    y:        bus.mul_y,
    rob_ptr:  bus.mul_rob_ptr,
    gpr_val:  bus.mul_gpr_val,
    gpr_ptr:  bus.mul_gpr_ptr,
    hilo_val: bus.mul_hilo_val,
    hilo_ptr: bus.mul_hilo_ptr
  };

  mul_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_out = w_valid ? w_head : '0;

  assign bus.wb_valid     = w_valid;
  assign bus.wb_rob_ptr   = w_out.rob_ptr;
  assign bus.wb_gpr_val   = w_out.gpr_val;
  assign bus.wb_gpr_ptr   = w_out.gpr_ptr;
  assign bus.wb_gpr_data  = w_out.y[31:0];
  assign bus.wb_hilo_val  = w_out.hilo_val;
  assign bus.wb_hilo_ptr  = w_out.hilo_ptr;
  assign bus.wb_hilo_data = w_out.y;
  assign bus.overflow_err = r_ovf;
endmodule

// File: doc/mul_wb_queue.md
Name: mul_wb_queue

Overview:
- Receive side of the multiplier result interface: captures every completion from the fixed-latency (3-cycle), non-stallable multiply unit.
- Buffers completions in a small FIFO and presents them to the shared writeback/ROB-complete port with a valid/ready handshake.
- Provides issue credit so the scheduler never issues a multiply that could overflow the buffer.
- Supports pipeline flush by squashing in-flight and buffered results.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
MUL_LAT, 3, cycles from mul go to mul complete; fixed by the multiply unit

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  squash all buffered and in-flight results
mul_go  in  1  multiply issued this cycle (same signal that drives the unit's go)
mul_can_issue  out  1  credit: scheduler may assert mul_go this cycle
mul_complete  in  1  result valid from multiply unit
mul_y  in  64  result (full product, or madd/msub sum)
mul_rob_ptr  in  5  ROB index
mul_gpr_val  in  1  destination is GPR (MUL form)
mul_gpr_ptr  in  6  GPR physical register
mul_hilo_val  in  1  destination is HI/LO pair
mul_hilo_ptr  in  2  HI/LO physical register
wb_valid  out  1  head entry available
wb_ready  in  1  writeback port accepts head
wb_rob_ptr  out  5  head ROB index
wb_gpr_val  out  1  head writes GPR
wb_gpr_ptr  out  6  head GPR pointer
wb_gpr_data  out  32  head mul_y[31:0]
wb_hilo_val  out  1  head writes HI/LO
wb_hilo_ptr  out  2  head HI/LO pointer
wb_hilo_data  out  64  head full mul_y
overflow_err  out  1  sticky: result arrived into a full FIFO

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, in-flight shadows cleared, overflow_err=0. All wb_* outputs 0; mul_can_issue=1.
- In-flight tracking: 3-bit shift register s, s[0]<=mul_go, s[i]<=s[i-1]. Parallel kill-valid shadow v, v[0]<=mul_go&~flush, v[i]<=v[i-1]&~flush.
- pending = count + popcount(s). mul_can_issue = (pending < DEPTH), combinational, conservative (ignores same-cycle pop).
- Push: when mul_complete & v[2] & ~flush, write {y,rob,gpr_val,gpr_ptr,hilo_val,hilo_ptr} at tail.
- mul_complete with v[2]=0 is silently dropped (squashed).
- mul_complete without s[2] is a protocol error; overflow_err is set.
- Pop: wb_valid & wb_ready; head advances.
- wb_valid = (count != 0). Outputs come from the head register, so latency from mul_complete to wb_valid is 1 cycle when the FIFO is empty.
- wb_* fields hold stable while wb_valid & ~wb_ready.
- wb_* are zero when empty. wb_gpr_val/wb_hilo_val are qualified by wb_valid.
- Simultaneous push and pop: allowed at any count, count unchanged. At count=DEPTH with pop, the push succeeds.
- Push at count=DEPTH without pop: entry discarded, overflow_err<=1. Cannot occur while the credit is honoured.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- flush: next cycle count=0, head=tail, v=0. s keeps shifting so credit stays correct until the squashed results drain. mul_go in the flush cycle is killed.
- flush and wb_ready in the same cycle: flush wins; no handshake is reported as completed. The consumer treats flush as dominant.
- Reset asserted mid-operation: immediate clear of all state; overflow_err cleared only by reset.

Decomposition:
- Shared package mul_pkg:
  - MUL_LAT.
  - Pointer widths: ROB 5, GPR PRF 6, HILO PRF 2.
  - Opcode constants for MULT/MULTU/MADD/MSUB/MUL.
  - Packed struct mul_wb_entry_t {y, rob_ptr, gpr_val, gpr_ptr, hilo_val, hilo_ptr}.
- One sub-module: mul_wb_fifo, a generic DEPTH-entry synchronous FIFO of mul_wb_entry_t with push/pop/flush/count. The top holds the credit shift registers and field unpacking.

Test Plan:
- Single MUL: go at cycle 0, complete at cycle 3 with y=64'h0000_0001_0000_0006, gpr_val=1, gpr_ptr=12, rob=5, wb_ready=1 -> wb_valid cycle 4, wb_gpr_data=32'h6, wb_rob_ptr=5, gpr_val=1, hilo_val=0, then empty.
- Backpressure: wb_ready=0, go on 4 consecutive cycles -> mul_can_issue falls after the 4th go. After 4 completions count=4, a 5th go is never granted. wb_ready=1 drains rob order 0,1,2,3 one per cycle; credit returns the cycle after the first pop.
- Full plus simultaneous push/pop: count=4, wb_ready=1 on the cycle a fresh complete arrives (credit forced in the bench) -> count stays 4, overflow_err=0. Same arrival with wb_ready=0 -> overflow_err=1 sticky.
- Flush: 2 buffered entries plus 2 in flight, flush pulse -> wb_valid=0 next cycle. Both later completions are dropped, count stays 0. mul_can_issue returns to 1 within 3 cycles.
- HILO write: madd result y=64'hFFFF_FFFF_0000_0010, hilo_val=1, hilo_ptr=2 -> wb_hilo_data equals y, wb_gpr_val=0.
- Async reset: assert reset (low) mid-drain with count=3 and no clock edge -> wb_valid=0 and mul_can_issue=1 immediately. After release, idle with no spurious wb_valid.
